// File: rtl/bcd_subtractor_serial.sv
// Digit-serial BCD subtractor: diff = a - b - bin, one digit per clock, LSD first.
// Define BCD_SUB_MAGNITUDE_EN to turn negative results into |a - b - bin| (bout stays 1).
module bcd_subtractor_serial #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] diff,
  output logic                bout,
  output logic                invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
`ifdef BCD_SUB_MAGNITUDE_EN
  localparam logic [1:0] S_NEG  = 2'd3;
`endif

  logic [1:0]    state;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  acc;
  logic [IW-1:0] idx;
  logic          br;
  logic          inv_acc;

  logic [3:0]    a_dig;
  logic [3:0]    b_dig;
  logic [4:0]    t;
  logic          neg;
  logic [3:0]    d;
  logic [W-1:0]  next_acc;
  logic          last;
  logic          dig_bad;

  // One digit of a - b - br in 5-bit two's complement; t[4] is the sign.
  assign a_dig    = a_sh[3:0];
  assign b_dig    = b_sh[3:0];
  assign t        = {1'b0, a_dig} - {1'b0, b_dig} - {4'b0000, br};
  assign neg      = t[4];
  assign d        = neg ? (t[3:0] + 4'd10) : t[3:0];
  assign next_acc = {d, acc[W-1:4]};
  assign last     = (idx == IW'(DIGITS - 1));
  assign dig_bad  = (a_dig > 4'd9) || (b_dig > 4'd9);

  assign busy = (state != S_IDLE);
  assign done = (state == S_FIN);

  // NOTE: every register here, datapath included, is reset so an aborted
  // operation leaves no trace and invalid-digit results stay deterministic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      idx     <= '0;
      br      <= 1'b0;
      inv_acc <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
      invalid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all state advances together on the edge.
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            br      <= bin;
            idx     <= '0;
            inv_acc <= 1'b0;
            state   <= S_CALC;
          end
        end
        S_CALC: begin
          a_sh    <= a_sh >> 4;
          b_sh    <= b_sh >> 4;
          acc     <= next_acc;
          br      <= neg;
          idx     <= idx + 1'b1;
          inv_acc <= inv_acc | dig_bad;
          if (last) begin
`ifdef BCD_SUB_MAGNITUDE_EN
            if (neg) begin
              // Second pass computes 0 - (ten's complement) to get the magnitude.
              a_sh  <= '0;
              b_sh  <= next_acc;
              br    <= 1'b0;
              idx   <= '0;
              state <= S_NEG;
            end else begin
              diff    <= next_acc;
              bout    <= 1'b0;
              invalid <= inv_acc | dig_bad;
              state   <= S_FIN;
            end
`else
            diff    <= next_acc;
            bout    <= neg;
            invalid <= inv_acc | dig_bad;
            state   <= S_FIN;
`endif
          end
        end
`ifdef BCD_SUB_MAGNITUDE_EN
        S_NEG: begin
          a_sh <= a_sh >> 4;
          b_sh <= b_sh >> 4;
          acc  <= next_acc;
          br   <= neg;
          idx  <= idx + 1'b1;
          if (last) begin
            diff    <= next_acc;
            bout    <= 1'b1;
            invalid <= inv_acc;
            state   <= S_FIN;
          end
        end
`endif
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// Self-checking bench for bcd_subtractor_serial: decimal-arithmetic model plus
// literal expectations; one process compares held outputs on every clock.
module tb_bcd_subtractor_serial;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         invalid;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         invalid;

  int checks   = 0;
  int failures = 0;
  res_t exp_q[$];

  bcd_subtractor_serial #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Decimal value of each operand, subtract, then re-encode.
  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
    res_t r;
    int av, bv, v, full;
    av = 0; bv = 0; full = 1;
    r.invalid = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      av = av * 10 + int'(ma[4*i +: 4]);
      bv = bv * 10 + int'(mb[4*i +: 4]);
      if (ma[4*i +: 4] > 4'd9 || mb[4*i +: 4] > 4'd9) r.invalid = 1'b1;
      full = full * 10;
    end
    v = av - bv - int'(mbin);
    r.bout = (v < 0);
    if (v >= 0) r.diff = to_bcd(v);
`ifdef BCD_SUB_MAGNITUDE_EN
    else r.diff = to_bcd((-v) % full);
`else
    else r.diff = to_bcd(v + full);
`endif
    return r;
  endfunction

  function automatic int exp_latency(input res_t r);
`ifdef BCD_SUB_MAGNITUDE_EN
    if (r.bout) return 2 * DIGITS + 1;
`endif
    return DIGITS + 1;
  endfunction

  // Compare process: outputs must always equal the most recent completed result.
  initial begin
    res_t cur;
    cur = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cur = '0;
        check("reset_outputs", {15'd0, done, busy, bout, invalid, diff}, 32'd0);
      end else begin
        if (done) begin
          if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
          else cur = exp_q.pop_front();
        end
        check("invalid_hold", invalid, cur.invalid);
        if (!cur.invalid) begin
          check("diff_hold", diff, cur.diff);
          check("bout_hold", bout, cur.bout);
        end
      end
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin);
    res_t e;
    int k;
    e = model(ta, tb_v, tbin);
    @(negedge clk);
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0; a = 16'hFFFF; b = 16'h5A5A; bin = ~tbin;
    k = 1;
    while (!done && k < 40) begin
      check("busy_during_op", busy, 1'b1);
      @(negedge clk);
      k++;
    end
    check("done_latency", k, exp_latency(e));
    check("busy_at_done", busy, 1'b1);
    @(negedge clk);
    check("done_one_cycle", {busy, done}, 2'b00);
  endtask

  initial begin
    int dcount;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_diff", diff, 16'h0000);
    check("rst_flags", {busy, done, bout, invalid}, 4'b0000);
    #1 rst = 1'b0;

    run_op(16'h4321, 16'h1234, 1'b0);
    check("t1_diff", diff, 16'h3087);
    check("t1_flags", {bout, invalid}, 2'b00);

    run_op(16'h0000, 16'h0001, 1'b0);
`ifdef BCD_SUB_MAGNITUDE_EN
    check("t2_diff", diff, 16'h0001);
`else
    check("t2_diff", diff, 16'h9999);
`endif
    check("t2_bout", bout, 1'b1);

    run_op(16'h1000, 16'h0999, 1'b1);
    check("t3_diff", diff, 16'h0000);
    check("t3_bout", bout, 1'b0);

    run_op(16'h00A0, 16'h0000, 1'b0);
    check("t4_invalid", invalid, 1'b1);
    check("t4_bout", bout, 1'b0);

    // Start while busy with new operands must be ignored.
    @(negedge clk);
    a = 16'h4321; b = 16'h1234; bin = 1'b0; start = 1'b1;
    exp_q.push_back(model(16'h4321, 16'h1234, 1'b0));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'h9999; b = 16'h0000; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcount = 0;
    while (!done && dcount < 40) begin @(negedge clk); dcount++; end
    check("t5_ignored_diff", diff, 16'h3087);
    check("t5_ignored_flags", {bout, invalid}, 2'b00);
    repeat (12) @(negedge clk);

    // Reset in the middle of an operation aborts with no done pulse.
    @(negedge clk);
    a = 16'h0500; b = 16'h0123; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_diff", diff, 16'h0000);
    @(negedge clk);
    #1 rst = 1'b0;
    dcount = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("t5_no_done_after_rst", dcount, 0);

    run_op(16'h0500, 16'h0123, 1'b0);
    check("t5_after_rst_diff", diff, 16'h0377);
    check("t5_after_rst_bout", bout, 1'b0);

    run_op(16'h0000, 16'h9999, 1'b1);
    check("t6_diff", diff, 16'h0000);
    check("t6_bout", bout, 1'b1);

    run_op(16'h9999, 16'h0000, 1'b0);
    check("x1_diff", diff, 16'h9999);
    run_op(16'h5678, 16'h1234, 1'b1);
    check("x2_diff", diff, 16'h4443);
    run_op(16'h1234, 16'h5678, 1'b0);
`ifdef BCD_SUB_MAGNITUDE_EN
    check("x3_diff", diff, 16'h4444);
`else
    check("x3_diff", diff, 16'h5556);
`endif
    check("x3_bout", bout, 1'b1);
    run_op(16'h0000, 16'h0000, 1'b1);
    check("x4_bout", bout, 1'b1);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
